// File: rtl/drum_pkg.sv
// drum_pkg: shared state encoding, default sizes and voice indices for the drum voice counter
package drum_pkg;

    localparam int DEF_NUM_CH  = 4;
    localparam int DEF_ADDR_W  = 15;

    localparam int VOICE_KICK  = 0;
    localparam int VOICE_SNARE = 1;
    localparam int VOICE_HAT   = 2;
    localparam int VOICE_TOM   = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PLAY = 1'b1
    } state_e;

endpackage

// File: rtl/drum_voice_chan.sv
// drum_voice_chan: one drum voice stepping a sample-ROM address from 0 to len-1
// Optional looping of a sample is enabled by defining DRUM_VOICE_LOOP_EN (adds loop_i).
module drum_voice_chan
    import drum_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en_i,
    input  logic              go_i,
`ifdef DRUM_VOICE_LOOP_EN
    input  logic              loop_i,
`endif
    input  logic [ADDR_W-1:0] len_i,
    output logic [ADDR_W-1:0] count_o,
    output logic              active_o,
    output logic              done_o
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] count_q, count_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic              done_q, done_d;
    logic              wrap;
    logic              at_last;

`ifdef DRUM_VOICE_LOOP_EN
    assign wrap = loop_i;
`else
    assign wrap = 1'b0;
`endif

    assign at_last = (count_q == len_q - ADDR_W'(1));

    // next state: a trigger beats the sample tick; the last address either ends or wraps the voice
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        len_d   = len_q;
        done_d  = 1'b0;
        if (go_i) begin
            count_d = '0;
            len_d   = len_i;
            state_d = (len_i != '0) ? ST_PLAY : ST_IDLE;
            done_d  = (len_i == '0);
        end else if (state_q == ST_PLAY && en_i) begin
            count_d = (at_last && !wrap) ? count_q : (at_last ? '0 : count_q + ADDR_W'(1));
            state_d = (at_last && !wrap) ? ST_IDLE : ST_PLAY;
            done_d  = at_last;
        end
    end

    // voice registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            len_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            len_q   <= len_d;
            done_q  <= done_d;
        end
    end

    assign count_o  = count_q;
    assign active_o = (state_q == ST_PLAY);
    assign done_o   = done_q;

endmodule

// File: rtl/drum_voice_counter.sv
// drum_voice_counter: NUM_CH independent drum voices sharing one sample-rate tick
// Defining DRUM_VOICE_LOOP_EN adds a per-voice loop input that repeats the sample.
module drum_voice_counter
    import drum_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic [NUM_CH-1:0]        go,
`ifdef DRUM_VOICE_LOOP_EN
    input  logic [NUM_CH-1:0]        loop,
`endif
    input  logic [NUM_CH*ADDR_W-1:0] len,
    output logic [NUM_CH*ADDR_W-1:0] count,
    output logic [NUM_CH-1:0]        active,
    output logic [NUM_CH-1:0]        done,
    output logic                     any_active
);

    genvar i;
    generate
        for (i = 0; i < NUM_CH; i++) begin : g_ch
            drum_voice_chan #(.ADDR_W(ADDR_W)) u_chan (
                .clk      (clk),
                .reset    (reset),
                .en_i     (en),
                .go_i     (go[i]),
`ifdef DRUM_VOICE_LOOP_EN
                .loop_i   (loop[i]),
`endif
                .len_i    (len[i*ADDR_W +: ADDR_W]),
                .count_o  (count[i*ADDR_W +: ADDR_W]),
                .active_o (active[i]),
                .done_o   (done[i])
            );
        end
    endgenerate

    assign any_active = |active;

endmodule

// File: tb/tb_drum_voice_counter.sv
// tb_drum_voice_counter: directed scoreboard bench for drum_voice_counter
module tb_drum_voice_counter;
    import drum_pkg::*;

    localparam int NC = 4;
    localparam int AW = 15;

    typedef struct {
        int          ch;
        logic [14:0] cnt;
        logic        act;
        logic        dn;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              en;
    logic [NC-1:0]     go;
    logic [NC-1:0]     loop;
    logic [NC*AW-1:0]  len;
    logic [NC*AW-1:0]  count;
    logic [NC-1:0]     active;
    logic [NC-1:0]     done;
    logic              any_active;

    exp_t  q[$];
    int    checks = 0;
    int    errors = 0;
    string phase  = "reset";

    drum_voice_counter #(.NUM_CH(NC), .ADDR_W(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .go         (go),
`ifdef DRUM_VOICE_LOOP_EN
        .loop       (loop),
`endif
        .len        (len),
        .count      (count),
        .active     (active),
        .done       (done),
        .any_active (any_active)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic expect_v(input int ch, input int cnt, input logic act, input logic dn);
        exp_t e;
        e.ch  = ch;
        e.cnt = 15'(cnt);
        e.act = act;
        e.dn  = dn;
        q.push_back(e);
    endtask

    task automatic cyc();
        exp_t e;
        @(posedge clk);
        #1;
        while (q.size() > 0) begin
            e = q.pop_front();
            chk($sformatf("%s.count[%0d]", phase, e.ch), 32'(count[e.ch*AW +: AW]), 32'(e.cnt));
            chk($sformatf("%s.active[%0d]", phase, e.ch), 32'(active[e.ch]), 32'(e.act));
            chk($sformatf("%s.done[%0d]", phase, e.ch), 32'(done[e.ch]), 32'(e.dn));
        end
    endtask

    task automatic set_len(input int ch, input int l);
        len[ch*AW +: AW] = 15'(l);
    endtask

    initial begin
        reset = 1'b1;
        en    = 1'b0;
        go    = '0;
        loop  = '0;
        len   = '0;

        // reset held for two cycles
        for (int c = 0; c < 2; c++) begin
            for (int v = 0; v < NC; v++) expect_v(v, 0, 1'b0, 1'b0);
            cyc();
        end
        chk("reset.any_active", 32'(any_active), 32'd0);

        // idle with en toggling and no trigger
        phase = "idle";
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            en = c[0];
            for (int v = 0; v < NC; v++) expect_v(v, 0, 1'b0, 1'b0);
            cyc();
        end

        // basic play on the snare voice, len 4, en every cycle
        phase = "basic";
        en = 1'b1;
        go[VOICE_SNARE] = 1'b1;
        set_len(VOICE_SNARE, 4);
        expect_v(VOICE_SNARE, 0, 1'b1, 1'b0);
        cyc();
        chk("basic.any_active", 32'(any_active), 32'd1);
        go = '0;
        for (int k = 1; k < 4; k++) begin
            expect_v(VOICE_SNARE, k, 1'b1, 1'b0);
            cyc();
        end
        expect_v(VOICE_SNARE, 3, 1'b0, 1'b1);
        cyc();
        for (int c = 0; c < 2; c++) begin
            expect_v(VOICE_SNARE, 3, 1'b0, 1'b0);
            expect_v(VOICE_KICK, 0, 1'b0, 1'b0);
            expect_v(VOICE_HAT, 0, 1'b0, 1'b0);
            expect_v(VOICE_TOM, 0, 1'b0, 1'b0);
            cyc();
        end
        chk("basic.any_idle", 32'(any_active), 32'd0);

        // sparse tick: len 3, en once every 5 cycles
        phase = "sparse";
        en = 1'b0;
        go[VOICE_HAT] = 1'b1;
        set_len(VOICE_HAT, 3);
        expect_v(VOICE_HAT, 0, 1'b1, 1'b0);
        cyc();
        go = '0;
        for (int c = 0; c < 4; c++) begin
            expect_v(VOICE_HAT, 0, 1'b1, 1'b0);
            cyc();
        end
        for (int p = 0; p < 3; p++) begin
            en = 1'b1;
            if (p == 2) expect_v(VOICE_HAT, 2, 1'b0, 1'b1);
            else        expect_v(VOICE_HAT, p + 1, 1'b1, 1'b0);
            cyc();
            en = 1'b0;
            for (int c = 0; c < 4; c++) begin
                if (p == 2) expect_v(VOICE_HAT, 2, 1'b0, 1'b0);
                else        expect_v(VOICE_HAT, p + 1, 1'b1, 1'b0);
                cyc();
            end
        end

        // retrigger the kick mid-play with a shorter length
        phase = "retrig";
        en = 1'b1;
        go[VOICE_KICK] = 1'b1;
        set_len(VOICE_KICK, 10);
        expect_v(VOICE_KICK, 0, 1'b1, 1'b0);
        cyc();
        go = '0;
        for (int k = 1; k <= 6; k++) begin
            expect_v(VOICE_KICK, k, 1'b1, 1'b0);
            cyc();
        end
        go[VOICE_KICK] = 1'b1;
        set_len(VOICE_KICK, 2);
        expect_v(VOICE_KICK, 0, 1'b1, 1'b0);
        cyc();
        go = '0;
        expect_v(VOICE_KICK, 1, 1'b1, 1'b0);
        cyc();
        expect_v(VOICE_KICK, 1, 1'b0, 1'b1);
        cyc();
        expect_v(VOICE_KICK, 1, 1'b0, 1'b0);
        cyc();

        // simultaneous: retrigger on the final tick, and an empty sample
        phase = "simul";
        go[VOICE_HAT] = 1'b1;
        go[VOICE_TOM] = 1'b1;
        set_len(VOICE_HAT, 2);
        set_len(VOICE_TOM, 2);
        expect_v(VOICE_HAT, 0, 1'b1, 1'b0);
        expect_v(VOICE_TOM, 0, 1'b1, 1'b0);
        cyc();
        go = '0;
        expect_v(VOICE_HAT, 1, 1'b1, 1'b0);
        expect_v(VOICE_TOM, 1, 1'b1, 1'b0);
        cyc();
        go[VOICE_HAT] = 1'b1;
        go[VOICE_TOM] = 1'b1;
        set_len(VOICE_TOM, 0);
        expect_v(VOICE_HAT, 0, 1'b1, 1'b0);
        expect_v(VOICE_TOM, 0, 1'b0, 1'b1);
        cyc();
        go = '0;
        expect_v(VOICE_HAT, 1, 1'b1, 1'b0);
        expect_v(VOICE_TOM, 0, 1'b0, 1'b0);
        cyc();
        expect_v(VOICE_HAT, 1, 1'b0, 1'b1);
        expect_v(VOICE_TOM, 0, 1'b0, 1'b0);
        cyc();
        chk("simul.any_idle", 32'(any_active), 32'd0);

`ifdef DRUM_VOICE_LOOP_EN
        // looping kick, len 3, then clear loop to let it finish
        phase = "loop";
        loop[VOICE_KICK] = 1'b1;
        go[VOICE_KICK] = 1'b1;
        set_len(VOICE_KICK, 3);
        expect_v(VOICE_KICK, 0, 1'b1, 1'b0);
        cyc();
        go = '0;
        expect_v(VOICE_KICK, 1, 1'b1, 1'b0);
        cyc();
        expect_v(VOICE_KICK, 2, 1'b1, 1'b0);
        cyc();
        expect_v(VOICE_KICK, 0, 1'b1, 1'b1);
        cyc();
        expect_v(VOICE_KICK, 1, 1'b1, 1'b0);
        cyc();
        expect_v(VOICE_KICK, 2, 1'b1, 1'b0);
        cyc();
        loop = '0;
        expect_v(VOICE_KICK, 2, 1'b0, 1'b1);
        cyc();
        expect_v(VOICE_KICK, 2, 1'b0, 1'b0);
        cyc();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
